// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer
//   Sequences register-to-register moves over a shared output-enabled bus.
//   Two requesters (A, B) are arbitrated round-robin. An accepted request
//   drives enable[src] for two cycles, pulses load[dst] in the second one,
//   then reports done. Malformed requests (src==dst or an index past NREG)
//   are answered with a one-cycle err pulse and never touch the bus.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   a_valid/a_src/a_dst   port A request; a_ready = accepted this cycle
//   b_valid/b_src/b_dst   port B request; b_ready = accepted this cycle
//   enable[NREG]          one-hot output-enable strobes to the registers
//   load[NREG]            one-hot load strobes to the registers
//   busy                  sequencer not idle
//   done / err            one-cycle completion / rejection pulses
//   done_port             owner of the completed/rejected request (0=A, 1=B)
//   xfer_count            successful transfers, wraps at 2^CNT_W
module reg_bus_sequencer #(
   parameter int NREG  = 4,
   parameter int IDX_W = 2,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [IDX_W-1:0] a_src,
   input  logic [IDX_W-1:0] a_dst,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [IDX_W-1:0] b_src,
   input  logic [IDX_W-1:0] b_dst,
   output logic             b_ready,
   output logic [NREG-1:0]  enable,
   output logic [NREG-1:0]  load,
   output logic             busy,
   output logic             done,
   output logic             done_port,
   output logic             err,
   output logic [CNT_W-1:0] xfer_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DRIVE = 3'd1;
   localparam logic [2:0] LATCH = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;

   // One extra bit so NREG == 2^IDX_W still compares correctly.
   localparam logic [IDX_W:0] NREG_L = (IDX_W + 1)'(NREG);

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] src_q, src_d;
   logic [IDX_W-1:0] dst_q, dst_d;
   logic             port_q, port_d;
   logic             rr_q, rr_d;       // 0: A preferred on contention, 1: B
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             idle;
   logic             gnt_a, gnt_b;
   logic [IDX_W-1:0] req_src, req_dst;
   logic             req_bad;

   assign idle  = (state_q == IDLE);
   assign gnt_a = idle && a_valid && (!b_valid || !rr_q);
   assign gnt_b = idle && b_valid && (!a_valid ||  rr_q);

   // state_q is already IDLE while reset is high, but the readies are
   // combinational on the valids, so they need an explicit reset gate.
   assign a_ready = gnt_a && !reset;
   assign b_ready = gnt_b && !reset;

   assign req_src = gnt_b ? b_src : a_src;
   assign req_dst = gnt_b ? b_dst : a_dst;
   assign req_bad = (req_src == req_dst) ||
                    ({1'b0, req_src} >= NREG_L) ||
                    ({1'b0, req_dst} >= NREG_L);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      port_d  = port_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (gnt_a || gnt_b) begin
               src_d   = req_src;
               dst_d   = req_dst;
               port_d  = gnt_b;
               rr_d    = !gnt_b;
               state_d = req_bad ? ERR : DRIVE;
            end
         end
         DRIVE: state_d = LATCH;
         LATCH: state_d = DONE;
         DONE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         port_q  <= 1'b0;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         port_q  <= port_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore strobes: indices are range-checked before DRIVE is entered, so
   // the decodes below are one-hot whenever they are active, and load[src]
   // cannot fire because src != dst.
   always_comb begin
      enable = '0;
      load   = '0;
      for (int i = 0; i < NREG; i++) begin
         if ((state_q == DRIVE || state_q == LATCH) && src_q == IDX_W'(i))
            enable[i] = 1'b1;
         if (state_q == LATCH && dst_q == IDX_W'(i))
            load[i] = 1'b1;
      end
   end

   assign busy       = !idle;
   assign done       = (state_q == DONE);
   assign err        = (state_q == ERR);
   assign done_port  = (done || err) && port_q;
   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer. Two instances: u0 (NREG=4, CNT_W=8) and
// u1 (NREG=3, CNT_W=2). A per-instance transaction model schedules the
// expected per-cycle outputs of every granted request into a queue and a
// compare loop checks all outputs on each falling edge.
module tb_reg_bus_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // request channel index i = dut*2 + port (port 0=A, 1=B)
   logic [3:0]      vld, rdy;
   logic [3:0][1:0] sv, dv;
   logic [3:0]      en0, ld0;
   logic [2:0]      en1, ld1;
   logic [1:0]      bsy, dn, er, dp;
   logic [7:0]      cnt0;
   logic [1:0]      cnt1;

   reg_bus_sequencer #(.NREG(4), .IDX_W(2), .CNT_W(8)) u0 (
      .clock(clk), .reset(rst),
      .a_valid(vld[0]), .a_src(sv[0]), .a_dst(dv[0]), .a_ready(rdy[0]),
      .b_valid(vld[1]), .b_src(sv[1]), .b_dst(dv[1]), .b_ready(rdy[1]),
      .enable(en0), .load(ld0), .busy(bsy[0]), .done(dn[0]),
      .done_port(dp[0]), .err(er[0]), .xfer_count(cnt0));

   reg_bus_sequencer #(.NREG(3), .IDX_W(2), .CNT_W(2)) u1 (
      .clock(clk), .reset(rst),
      .a_valid(vld[2]), .a_src(sv[2]), .a_dst(dv[2]), .a_ready(rdy[2]),
      .b_valid(vld[3]), .b_src(sv[3]), .b_dst(dv[3]), .b_ready(rdy[3]),
      .enable(en1), .load(ld1), .busy(bsy[1]), .done(dn[1]),
      .done_port(dp[1]), .err(er[1]), .xfer_count(cnt1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [1:0] s;
      logic [1:0] t;
   } rq_t;

   typedef struct packed {
      logic [3:0] en;
      logic [3:0] ld;
      logic       dn;
      logic       er;
      logic       pt;
   } rec_t;

   rq_t  pq [4][$];     // pending requests per channel
   logic [3:0] hs = '0; // ready seen before the coming rising edge
   rec_t mq [2][$];     // model: expected outputs of the cycles ahead
   int   mcnt [2];
   int   pref [2];
   int   dq [2][$];     // observed done_port of each done/err pulse
   int   nreg [2] = '{4, 3};
   int   cmod [2] = '{256, 4};

   // requester: holds valid/src/dst until the handshake edge
   initial begin
      vld = '0; sv = '0; dv = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (hs[i] && pq[i].size() > 0) pq[i].delete(0);
            if (pq[i].size() > 0) begin
               vld[i] = 1'b1;
               sv[i]  = pq[i][0].s;
               dv[i]  = pq[i][0].t;
            end else begin
               vld[i] = 1'b0;
            end
         end
      end
   end

   // model + compare, every falling edge
   rec_t e;
   logic ea, eb, ebusy, p, bad;
   int   s, t, ae, al, ac;
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            e = '0; ea = 0; eb = 0; ebusy = 0;
            if (rst) begin
               mq[d].delete();
               mcnt[d] = 0;
               pref[d] = 0;
            end else if (mq[d].size() > 0) begin
               e = mq[d].pop_front();
               ebusy = 1;
            end else begin
               ea = vld[2*d]   && (!vld[2*d+1] || pref[d] == 0);
               eb = vld[2*d+1] && (!vld[2*d]   || pref[d] == 1);
               if (ea || eb) begin
                  p   = eb;
                  s   = sv[2*d+p];
                  t   = dv[2*d+p];
                  bad = (s == t) || (s >= nreg[d]) || (t >= nreg[d]);
                  if (bad) begin
                     mq[d].push_back('{en:4'd0, ld:4'd0, dn:1'b0, er:1'b1, pt:p});
                  end else begin
                     mq[d].push_back('{en:4'(1) << s, ld:4'd0, dn:1'b0, er:1'b0, pt:1'b0});
                     mq[d].push_back('{en:4'(1) << s, ld:4'(1) << t, dn:1'b0, er:1'b0, pt:1'b0});
                     mq[d].push_back('{en:4'd0, ld:4'd0, dn:1'b1, er:1'b0, pt:p});
                  end
                  pref[d] = p ? 0 : 1;
               end
            end
            ae = (d == 0) ? int'(en0) : int'(en1);
            al = (d == 0) ? int'(ld0) : int'(ld1);
            ac = (d == 0) ? int'(cnt0) : int'(cnt1);
            chk($sformatf("u%0d.enable", d), ae, int'(e.en));
            chk($sformatf("u%0d.load", d), al, int'(e.ld));
            chk($sformatf("u%0d.done", d), int'(dn[d]), int'(e.dn));
            chk($sformatf("u%0d.err", d), int'(er[d]), int'(e.er));
            chk($sformatf("u%0d.done_port", d), int'(dp[d]), int'(e.pt));
            chk($sformatf("u%0d.busy", d), int'(bsy[d]), int'(ebusy));
            chk($sformatf("u%0d.a_ready", d), int'(rdy[2*d]), int'(ea));
            chk($sformatf("u%0d.b_ready", d), int'(rdy[2*d+1]), int'(eb));
            chk($sformatf("u%0d.xfer_count", d), ac, mcnt[d]);
            if (!rst && e.dn) mcnt[d] = (mcnt[d] + 1) % cmod[d];
            if (dn[d] || er[d]) dq[d].push_back(int'(dp[d]));
            hs[2*d]   = rdy[2*d];
            hs[2*d+1] = rdy[2*d+1];
         end
      end
   end

   task automatic wait_idle(input int d);
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         #2;
         if (pq[2*d].size() == 0 && pq[2*d+1].size() == 0 &&
             vld[2*d+1 -: 2] == 2'b00 && mq[d].size() == 0 && !bsy[d]) break;
      end
      if (n == 300) chk($sformatf("u%0d.drain_timeout", d), n, 0);
   endtask

   task automatic chk_seq(input int d, input string nm, input int exp[]);
      chk({nm, ".count"}, dq[d].size(), exp.size());
      for (int i = 0; i < exp.size() && i < dq[d].size(); i++)
         chk($sformatf("%s[%0d]", nm, i), dq[d][i], exp[i]);
      dq[d].delete();
   endtask

   int tr_en[5], tr_ld[5], tr_dn[5], tr_rd[5];
   int x_en[5] = '{0, 2, 2, 0, 0};
   int x_ld[5] = '{0, 0, 8, 0, 0};
   int x_dn[5] = '{0, 0, 0, 1, 0};
   int x_rd[5] = '{1, 0, 0, 0, 0};

   initial begin
      int n;
      rst = 1'b1;
      // both ports valid while still in reset: A 0->2, B 3->1
      pq[0].push_back('{s:2'd0, t:2'd2});
      pq[1].push_back('{s:2'd3, t:2'd1});
      repeat (3) @(posedge clk);
      #2;
      chk("reset.readies", int'(rdy), 0);
      chk("reset.enable", int'(en0), 0);
      chk("reset.xfer_count", int'(cnt0), 0);
      chk("reset.busy", int'(bsy), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      wait_idle(0);
      chk_seq(0, "both.order", '{0, 1});
      chk("both.xfer_count", int'(cnt0), 2);

      // single A transfer 1 -> 3, literal cycle trace
      @(negedge clk);
      pq[0].push_back('{s:2'd1, t:2'd3});
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tr_en[c] = int'(en0); tr_ld[c] = int'(ld0);
         tr_dn[c] = int'(dn[0]); tr_rd[c] = int'(rdy[0]);
      end
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("single.enable[%0d]", c), tr_en[c], x_en[c]);
         chk($sformatf("single.load[%0d]", c), tr_ld[c], x_ld[c]);
         chk($sformatf("single.done[%0d]", c), tr_dn[c], x_dn[c]);
         chk($sformatf("single.a_ready[%0d]", c), tr_rd[c], x_rd[c]);
      end
      chk("single.xfer_count", int'(cnt0), 3);
      chk_seq(0, "single.port", '{0});

      // rejected request on B: src == dst
      @(negedge clk);
      pq[1].push_back('{s:2'd2, t:2'd2});
      wait_idle(0);
      chk_seq(0, "err.port", '{1});
      chk("err.xfer_count", int'(cnt0), 3);

      // reset asserted during LATCH
      @(negedge clk);
      pq[0].push_back('{s:2'd0, t:2'd1});
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ld0 != 4'd0) break;
      end
      chk("midrst.reached_latch", int'(ld0), 2);
      #1 rst = 1'b1;
      #1;
      chk("midrst.enable", int'(en0), 0);
      chk("midrst.load", int'(ld0), 0);
      chk("midrst.xfer_count", int'(cnt0), 0);
      chk("midrst.busy", int'(bsy[0]), 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      dq[0].delete();

      // continuous traffic on both ports, starting from rr_ptr=A
      @(negedge clk);
      pq[0].push_back('{s:2'd1, t:2'd0});
      pq[0].push_back('{s:2'd2, t:2'd3});
      pq[1].push_back('{s:2'd0, t:2'd3});
      pq[1].push_back('{s:2'd3, t:2'd2});
      wait_idle(0);
      chk_seq(0, "cont.order", '{0, 1, 0, 1});
      chk("cont.xfer_count", int'(cnt0), 4);

      // NREG=3: src=3 is out of range
      @(negedge clk);
      pq[3].push_back('{s:2'd3, t:2'd0});
      wait_idle(1);
      chk_seq(1, "n3err.port", '{1});
      chk("n3err.xfer_count", int'(cnt1), 0);

      // CNT_W=2: five transfers wrap the counter to 1
      @(negedge clk);
      pq[2].push_back('{s:2'd0, t:2'd1});
      pq[2].push_back('{s:2'd1, t:2'd2});
      pq[2].push_back('{s:2'd2, t:2'd0});
      pq[2].push_back('{s:2'd0, t:2'd2});
      pq[2].push_back('{s:2'd1, t:2'd0});
      wait_idle(1);
      chk("wrap.xfer_count", int'(cnt1), 1);
      chk_seq(1, "wrap.port", '{0, 0, 0, 0, 0});

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
